// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode seven-segment scanner.
// Owns the slot prescaler, digit index, one-cold anode drive, hex decode,
// per-slot dead time and a double-buffered display value that only changes
// at frame wrap.
// Optional: define SEG_LZ_BLANK_EN to suppress leading zeros.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]                 cnt;
    logic [IW-1:0]                 idx;
    logic                          pend;
    logic [NUM_DIGITS-1:0][3:0]    disp_dig, pend_dig;
    logic [NUM_DIGITS-1:0]         disp_dp, pend_dp;
    logic                          slot_end, frame_wrap, blank_dig;

    assign slot_end   = en && (cnt == CNT_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

`ifdef SEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] suppress;
    logic                  zero_above;
    // A digit is a leading zero when it and every higher nibble is zero and
    // its own decimal point is off; digit 0 always shows
    always_comb begin
        suppress   = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            suppress[k] = zero_above && (disp_dig[k] == 4'h0) && !disp_dp[k];
            zero_above  = zero_above && (disp_dig[k] == 4'h0);
        end
    end
    assign blank_dig = suppress[idx];
`else
    assign blank_dig = 1'b0;
`endif

    // Slot prescaler and digit index; both freeze while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Double buffer: loads land in pending, committed at frame wrap so a
    // frame never mixes old and new digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            disp_dig <= '0;
            disp_dp  <= '0;
            pend_dig <= '0;
            pend_dp  <= '0;
        end else if (load && frame_wrap) begin
            disp_dig <= digits_in;
            disp_dp  <= dp_in;
            pend     <= 1'b0;
        end else begin
            if (frame_wrap && pend) begin
                disp_dig <= pend_dig;
                disp_dp  <= pend_dp;
                pend     <= 1'b0;
            end
            if (load) begin
                pend_dig <= digits_in;
                pend_dp  <= dp_in;
                pend     <= 1'b1;
            end
        end
    end

    // Registered pin drive: dead time, disable and suppression all blank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (!en || (cnt < CNT_BLANK) || blank_dig) begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= decode(disp_dig[idx]);
                dp  <= ~disp_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
// Expected pin values come from a behavioural model and are queued when the
// stimulus is applied, then popped after the clock edge that produces them.
module tb_seg_scan_ctrl;
    localparam int ND = 4, SC = 8, BC = 2;

    logic        clk = 0, rst_n = 0, en = 0, load = 0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_done;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .SLOT_CYCLES(SC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;
    exp_t q[$];

    int checks = 0, failures = 0;

    // Segment table written straight from the datasheet patterns
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    int          m_cnt, m_idx;
    logic [15:0] m_disp, m_pd;
    logic [3:0]  m_dpd, m_pp;
    bit          m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cnt = 0; m_idx = 0; m_disp = '0; m_pd = '0; m_dpd = '0; m_pp = '0; m_pend = 0;
        q.delete();
    endtask

    function automatic bit m_sup(input int k);
`ifdef SEG_LZ_BLANK_EN
        logic [15:0] d;
        d = m_disp;
        if (k == 0) return 0;
        for (int j = k + 1; j < ND; j++) if (d[j*4 +: 4] != 4'h0) return 0;
        return (d[k*4 +: 4] == 4'h0) && !m_dpd[k];
`else
        return k < 0;
`endif
    endfunction

    // One clock: apply inputs, predict the registered outputs, step model
    task automatic cycle(input bit l, input logic [15:0] d, input logic [3:0] p);
        exp_t e, g;
        bit   wrap;
        logic [15:0] dd;
        logic [3:0]  oh;
        load = l; digits_in = d; dp_in = p;
        wrap = en && m_idx == ND - 1 && m_cnt == SC - 1;
        e.fd = wrap;
        if (!en || m_cnt < BC || m_sup(m_idx)) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        end else begin
            dd = m_disp;
            oh = 4'h0; oh[m_idx] = 1'b1;
            e.an = ~oh; e.seg = seg_tab[dd[m_idx*4 +: 4]]; e.dp = ~m_dpd[m_idx];
        end
        q.push_back(e);
        if (l && wrap) begin
            m_disp = d; m_dpd = p; m_pend = 0;
        end else begin
            if (wrap && m_pend) begin m_disp = m_pd; m_dpd = m_pp; m_pend = 0; end
            if (l) begin m_pd = d; m_pp = p; m_pend = 1; end
        end
        if (en) begin
            if (m_cnt == SC - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % ND; end
            else m_cnt++;
        end
        @(posedge clk); #1;
        load = 0;
        g = q.pop_front();
        chk("an", {28'd0, an}, {28'd0, g.an});
        chk("seg", {25'd0, seg}, {25'd0, g.seg});
        chk("dp", {31'd0, dp}, {31'd0, g.dp});
        chk("frame_done", {31'd0, frame_done}, {31'd0, g.fd});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, 4'h0);
    endtask

    // Advance until the next cycle is the frame-wrap cycle (bounded)
    task automatic to_wrap();
        int n = 0;
        while (!(m_idx == ND - 1 && m_cnt == SC - 1) && n < 100) begin
            cycle(0, 16'h0, 4'h0); n++;
        end
        chk("wrap_reached", {31'd0, (n < 100)}, 32'd1);
    endtask

    initial begin
        m_reset();
        #13;
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        #10 rst_n = 1; en = 1;    // released at 23, first edge at 25

        // Idle scan of 0000: walk, dead time, frame pulse at cycle 32
        run(2);
        chk("c2_blank", {28'd0, an}, 32'hF);
        run(1);
        chk("c3_dig0", {28'd0, an}, 32'hE);
        chk("c3_seg0", {25'd0, seg}, 32'h40);
        run(29);
        chk("c32_fd", {31'd0, frame_done}, 32'd1);
        run(8);

        // Mid-frame load commits at the next wrap
        cycle(1, 16'h12AF, 4'b0100);
        run(56);

        // Last of two loads wins, then a load exactly on the wrap cycle
        cycle(1, 16'h1111, 4'h0);
        run(5);
        cycle(1, 16'h2222, 4'h0);
        to_wrap();
        run(1);
        run(32);
        to_wrap();
        cycle(1, 16'h3333, 4'h1);
        run(32);

        // Disable mid-slot for 10 cycles, then resume
        run(4);
        en = 0;
        run(10);
        en = 1;
        run(40);

        // Leading-zero patterns
        cycle(1, 16'h0050, 4'h0);
        to_wrap(); run(33);
        cycle(1, 16'h0000, 4'h0);
        to_wrap(); run(33);

        // Nonzero display, then asynchronous reset mid-slot
        cycle(1, 16'h9999, 4'hF);
        to_wrap(); run(13);
        #2 rst_n = 0;
        #1;
        chk("async_an", {28'd0, an}, 32'hF);
        chk("async_seg", {25'd0, seg}, 32'h7F);
        chk("async_dp", {31'd0, dp}, 32'd1);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1;
        run(3);
        chk("post_rst_dig0", {28'd0, an}, 32'hE);
        chk("post_rst_buf", {25'd0, seg}, 32'h40);
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised time-multiplexed scanner for common-anode seven-segment displays on the scoreboard path. It owns the refresh prescaler, the digit-select counter, the anode one-cold drive, hex-to-segment decode and inter-digit dead time. It double-buffers the displayed value so score updates never tear mid-frame. It sits between the score/BCD logic and the board pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (legal 2..16)
- SLOT_CYCLES, 100000, clk cycles per digit slot (must be > BLANK_CYCLES)
- BLANK_CYCLES, 1000, dead-time cycles at the start of each slot with all anodes off (legal 0..SLOT_CYCLES-1)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  scan enable; low blanks the display
- load  in  1  one-cycle strobe that captures digits_in/dp_in into the pending buffer
- digits_in  in  4*NUM_DIGITS  hex nibbles; nibble k is digit k (digit 0 is rightmost)
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- an  out  NUM_DIGITS  anode select, active-low, at most one bit low
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal-point cathode, active-low
- frame_done  out  1  one-cycle pulse on the last cycle of digit NUM_DIGITS-1

## Operation
- Slot counter cnt runs 0..SLOT_CYCLES-1 and wraps. Digit index idx advances when cnt == SLOT_CYCLES-1; it wraps from NUM_DIGITS-1 to 0 (frame wrap).
- cnt < BLANK_CYCLES: an all ones, seg 7'h7F, dp 1 (ghosting dead time). Otherwise an has bit idx low, seg = decode(display nibble idx), dp = ~display_dp[idx].
- Decode (active-low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Buffering: load writes the pending buffer and sets pend. At frame wrap with pend set, pending is copied to display and pend clears. Multiple loads within one frame: last wins. If load coincides with the frame-wrap cycle, digits_in/dp_in go straight to display and pend ends clear.
- en = 0: cnt and idx hold. Outputs are forced blank (an all ones, seg 7'h7F, dp 1). frame_done stays 0. Loads are still accepted. Scan resumes from the held position when en returns high.
- Arithmetic: cnt width is $clog2(SLOT_CYCLES). idx width is $clog2(NUM_DIGITS). Comparisons are unsigned.

## Timing
- an, seg, dp and frame_done are registered. Each reflects cnt/idx/en from the previous cycle (latency 1 clk).
- First lit digit after reset: an = ~1 (digit 0) starting at cycle BLANK_CYCLES+1 after rst_n deasserts.
- Frame period is NUM_DIGITS*SLOT_CYCLES cycles. frame_done is high exactly one cycle per frame, aligned (with the 1-cycle latency) to the cycle where idx = NUM_DIGITS-1 and cnt = SLOT_CYCLES-1.
- A committed value becomes visible at digit 0 of the next frame, after that slot's blank interval.
- Reset (asynchronous, any time including mid-slot):
  - an all ones, seg 7'h7F, dp 1, frame_done 0
  - cnt 0, idx 0, pend 0
  - display and pending buffers 0, all dp bits 0

## Configuration
- SEG_LZ_BLANK_EN defined: leading-zero suppression is enabled.
  - Digit k > 0 is suppressed when its nibble is 0, every display nibble above k is 0, and display_dp[k] = 0.
  - A suppressed digit keeps an high for its whole slot; the slot timing is unchanged.
  - Digit 0 is never suppressed.
- SEG_LZ_BLANK_EN undefined: every digit displays, including leading zeros.

## Test plan
Bench parameters: NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2.
- Reset then run 40 cycles with en=1 and display 0 -> an walks 1110, 1101, 1011, 0111. Each digit is low for 6 cycles after 2 all-ones cycles. seg=1000000 while lit. frame_done pulses at cycle 32.
- load with digits_in=16'h12AF, dp_in=4'b0100, issued mid-frame -> current frame still shows 0000. Next frame shows F, A, 2, 1 on digits 0..3, with dp=0 only on digit 2.
- Two loads in one frame (16'h1111 then 16'h2222) -> next frame shows 2222. A load on the frame-wrap cycle (16'h3333) -> visible in the frame that starts immediately.
- Drop en for 10 cycles mid-slot -> outputs blank during the gap. Resume continues the same idx with the remaining cnt. frame_done is delayed by exactly 10 cycles.
- With SEG_LZ_BLANK_EN, display 16'h0050 -> digits 3 and 2 keep an high, digits 1 and 0 are lit. Then 16'h0000 -> only digit 0 is lit, showing 0. Without the macro, all four digits are lit.
- Assert rst_n low at cycle 13 mid-slot -> outputs go blank immediately (asynchronous). After release, the scan restarts at digit 0 with buffers cleared.
